// File: rtl/digital_clock_param.sv
// 24-hour BCD clock with a parameterised seconds divider, run/pause, range-checked time and alarm load,
// a 12/24-hour display mapping, an hh:mm alarm and a day-rollover pulse.
module digital_clock_param #(
  parameter int CLK_DIV = 50
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic       alarm_load,
  input  logic       alarm_en,
  input  logic [1:0] ld_hours_p1,
  input  logic [3:0] ld_hours_p2,
  input  logic [2:0] ld_minutes_p1,
  input  logic [3:0] ld_minutes_p2,
  input  logic [2:0] ld_seconds_p1,
  input  logic [3:0] ld_seconds_p2,
  output logic [1:0] hours_p1,
  output logic [3:0] hours_p2,
  output logic [2:0] minutes_p1,
  output logic [3:0] minutes_p2,
  output logic [2:0] seconds_p1,
  output logic [3:0] seconds_p2,
  output logic       pm,
  output logic       tick_1hz,
  output logic       alarm_hit,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
    logic [2:0] s1;
    logic [3:0] s2;
  } bcd_time_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
  } bcd_hm_t;

  function automatic logic hour_ok(input logic [1:0] h1, input logic [3:0] h2);
    return (h2 <= 4'd9) && ((h1 < 2'd2) || ((h1 == 2'd2) && (h2 <= 4'd3)));
  endfunction

  function automatic logic sexa_ok(input logic [2:0] tens, input logic [3:0] units);
    return (tens <= 3'd5) && (units <= 4'd9);
  endfunction

  // Ripple one second through the BCD digits; hours wrap 23 -> 00.
  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.s2 != 4'd9) begin
      n.s2 = t.s2 + 4'd1;
    end else begin
      n.s2 = 4'd0;
      if (t.s1 != 3'd5) begin
        n.s1 = t.s1 + 3'd1;
      end else begin
        n.s1 = 3'd0;
        if (t.m2 != 4'd9) begin
          n.m2 = t.m2 + 4'd1;
        end else begin
          n.m2 = 4'd0;
          if (t.m1 != 3'd5) begin
            n.m1 = t.m1 + 3'd1;
          end else begin
            n.m1 = 3'd0;
            if ((t.h1 == 2'd2) && (t.h2 == 4'd3)) begin
              n.h1 = 2'd0;
              n.h2 = 4'd0;
            end else if (t.h2 != 4'd9) begin
              n.h2 = t.h2 + 4'd1;
            end else begin
              n.h2 = 4'd0;
              n.h1 = t.h1 + 2'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  logic [DW-1:0] div_q, div_d;
  bcd_time_t     time_q, time_d;
  bcd_hm_t       alarm_q, alarm_d;
  logic          tick_q, tick_d;
  logic          hit_q, hit_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  bcd_time_t     ld_time_s;
  bcd_time_t     next_time_s;
  logic          ld_time_ok_s;
  logic          ld_alarm_ok_s;
  logic          tick_due_s;
  logic [4:0]    hr_bin_s;
  logic [4:0]    hr_disp_s;

  // Next-state: a valid load wins outright; otherwise errors/alarm load coexist with the tick.
  always_comb begin
    div_d         = div_q;
    time_d        = time_q;
    alarm_d       = alarm_q;
    tick_d        = 1'b0;
    hit_d         = 1'b0;
    wrap_d        = 1'b0;
    err_d         = 1'b0;
    ld_time_s     = '{h1: ld_hours_p1, h2: ld_hours_p2, m1: ld_minutes_p1,
                      m2: ld_minutes_p2, s1: ld_seconds_p1, s2: ld_seconds_p2};
    ld_alarm_ok_s = hour_ok(ld_hours_p1, ld_hours_p2) && sexa_ok(ld_minutes_p1, ld_minutes_p2);
    ld_time_ok_s  = ld_alarm_ok_s && sexa_ok(ld_seconds_p1, ld_seconds_p2);
    tick_due_s    = run && (div_q == DIV_MAX);
    next_time_s   = time_inc(time_q);

    if (load && ld_time_ok_s) begin
      time_d = ld_time_s;
      div_d  = '0;
    end else begin
      if (load) begin
        err_d = 1'b1;
      end else if (alarm_load) begin
        if (ld_alarm_ok_s) begin
          alarm_d = '{h1: ld_hours_p1, h2: ld_hours_p2, m1: ld_minutes_p1, m2: ld_minutes_p2};
        end else begin
          err_d = 1'b1;
        end
      end else begin
        alarm_d = alarm_q;
      end

      if (tick_due_s) begin
        div_d  = '0;
        time_d = next_time_s;
        tick_d = 1'b1;
        wrap_d = (next_time_s == '0);
        hit_d  = alarm_en &&
                 (next_time_s.h1 == alarm_q.h1) && (next_time_s.h2 == alarm_q.h2) &&
                 (next_time_s.m1 == alarm_q.m1) && (next_time_s.m2 == alarm_q.m2) &&
                 (next_time_s.s1 == 3'd0) && (next_time_s.s2 == 4'd0);
      end else if (run) begin
        div_d = div_q + DW'(1);
      end else begin
        div_d = div_q;
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      time_q  <= '0;
      alarm_q <= '0;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      time_q  <= time_d;
      alarm_q <= alarm_d;
      tick_q  <= tick_d;
      hit_q   <= hit_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Display mapping: internal hours stay 24h; 12h mode only re-labels them.
  always_comb begin
    hr_bin_s = 5'(time_q.h1) * 5'd10 + 5'(time_q.h2);
    if (!mode_12h) begin
      hr_disp_s = hr_bin_s;
    end else if (hr_bin_s == 5'd0) begin
      hr_disp_s = 5'd12;
    end else if (hr_bin_s > 5'd12) begin
      hr_disp_s = hr_bin_s - 5'd12;
    end else begin
      hr_disp_s = hr_bin_s;
    end

    if (hr_disp_s >= 5'd20) begin
      hours_p1 = 2'd2;
      hours_p2 = 4'(hr_disp_s - 5'd20);
    end else if (hr_disp_s >= 5'd10) begin
      hours_p1 = 2'd1;
      hours_p2 = 4'(hr_disp_s - 5'd10);
    end else begin
      hours_p1 = 2'd0;
      hours_p2 = 4'(hr_disp_s);
    end

    pm         = (hr_bin_s >= 5'd12);
    minutes_p1 = time_q.m1;
    minutes_p2 = time_q.m2;
    seconds_p1 = time_q.s1;
    seconds_p2 = time_q.s2;
  end

  assign tick_1hz  = tick_q;
  assign alarm_hit = hit_q;
  assign day_wrap  = wrap_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_digital_clock_param.sv
// Randomised bench for digital_clock_param: time kept as seconds-of-day, alarm as minute-of-day.
module tb_digital_clock_param;

  localparam int DIV = 4;

  logic       master_clk = 1'b0;
  logic       reset, run, mode_12h, load, alarm_load, alarm_en;
  logic [1:0] ld_hours_p1;
  logic [3:0] ld_hours_p2;
  logic [2:0] ld_minutes_p1;
  logic [3:0] ld_minutes_p2;
  logic [2:0] ld_seconds_p1;
  logic [3:0] ld_seconds_p2;
  logic [1:0] hours_p1;
  logic [3:0] hours_p2;
  logic [2:0] minutes_p1;
  logic [3:0] minutes_p2;
  logic [2:0] seconds_p1;
  logic [3:0] seconds_p2;
  logic       pm, tick_1hz, alarm_hit, day_wrap, load_err;

  int total = 0;
  int bad   = 0;

  int m_t, m_div, m_alarm;
  bit m_tick, m_hit, m_wrap, m_err;
  int hit_cnt, wrap_cnt;

  always #5 master_clk = ~master_clk;

  digital_clock_param #(.CLK_DIV(DIV)) dut (
    .master_clk(master_clk), .reset(reset), .run(run), .mode_12h(mode_12h),
    .load(load), .alarm_load(alarm_load), .alarm_en(alarm_en),
    .ld_hours_p1(ld_hours_p1), .ld_hours_p2(ld_hours_p2),
    .ld_minutes_p1(ld_minutes_p1), .ld_minutes_p2(ld_minutes_p2),
    .ld_seconds_p1(ld_seconds_p1), .ld_seconds_p2(ld_seconds_p2),
    .hours_p1(hours_p1), .hours_p2(hours_p2),
    .minutes_p1(minutes_p1), .minutes_p2(minutes_p2),
    .seconds_p1(seconds_p1), .seconds_p2(seconds_p2),
    .pm(pm), .tick_1hz(tick_1hz), .alarm_hit(alarm_hit),
    .day_wrap(day_wrap), .load_err(load_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_t = 0; m_div = 0; m_alarm = 0;
    m_tick = 0; m_hit = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_edge();
    int  h, mi, s, new_alarm;
    bit  due, ok_hm, ok_t, set_alarm;
    m_tick = 0; m_hit = 0; m_wrap = 0; m_err = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    h  = int'(ld_hours_p1) * 10 + int'(ld_hours_p2);
    mi = int'(ld_minutes_p1) * 10 + int'(ld_minutes_p2);
    s  = int'(ld_seconds_p1) * 10 + int'(ld_seconds_p2);
    ok_hm = (ld_hours_p2 <= 9) && (h < 24) && (ld_minutes_p1 <= 5) && (ld_minutes_p2 <= 9);
    ok_t  = ok_hm && (ld_seconds_p1 <= 5) && (ld_seconds_p2 <= 9);
    due   = run && (m_div == DIV - 1);
    set_alarm = 0;
    new_alarm = 0;
    if (load && ok_t) begin
      m_t   = h * 3600 + mi * 60 + s;
      m_div = 0;
    end else begin
      if (load) m_err = 1;
      else if (alarm_load) begin
        if (ok_hm) begin set_alarm = 1; new_alarm = h * 60 + mi; end
        else m_err = 1;
      end
      if (due) begin
        m_div  = 0;
        m_t    = (m_t + 1) % 86400;
        m_tick = 1;
        m_wrap = (m_t == 0);
        m_hit  = alarm_en && (m_t == m_alarm * 60);
      end else if (run) begin
        m_div++;
      end
      if (set_alarm) m_alarm = new_alarm;
    end
  endtask

  task automatic compare_all();
    int h, dh, mi, s;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    check_val("hours",   32'({hours_p1, hours_p2}),     bcd2(dh));
    check_val("minutes", 32'({minutes_p1, minutes_p2}), bcd2(mi));
    check_val("seconds", 32'({seconds_p1, seconds_p2}), bcd2(s));
    check_val("pm",        32'(pm),        32'(h >= 12));
    check_val("tick_1hz",  32'(tick_1hz),  32'(m_tick));
    check_val("alarm_hit", 32'(alarm_hit), 32'(m_hit));
    check_val("day_wrap",  32'(day_wrap),  32'(m_wrap));
    check_val("load_err",  32'(load_err),  32'(m_err));
    if (alarm_hit === 1'b1) hit_cnt++;
    if (day_wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic step();
    @(posedge master_clk);
    model_edge();
    #1;
    compare_all();
    load       = 1'b0;
    alarm_load = 1'b0;
  endtask

  task automatic set_ld(input int secs);
    ld_hours_p1   = 2'((secs / 3600) / 10);
    ld_hours_p2   = 4'((secs / 3600) % 10);
    ld_minutes_p1 = 3'(((secs / 60) % 60) / 10);
    ld_minutes_p2 = 4'(((secs / 60) % 60) % 10);
    ld_seconds_p1 = 3'((secs % 60) / 10);
    ld_seconds_p2 = 4'((secs % 60) % 10);
  endtask

  initial begin
    int r;
    reset = 1'b0; run = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_load = 1'b0; alarm_en = 1'b0;
    set_ld(0);
    model_reset();
    #2;
    compare_all();
    mode_12h = 1'b1;
    #1;
    check_val("reset_12h", 32'({hours_p1, hours_p2, pm}), 32'({2'd1, 4'd2, 1'b0}));
    mode_12h = 1'b0;
    step(); step();
    reset = 1'b1;
    run   = 1'b1;

    repeat (40) step();
    check_val("ten_ticks", 32'({seconds_p1, seconds_p2}), 32'h10);
    repeat (200) step();
    check_val("one_min", 32'({minutes_p1, minutes_p2, seconds_p1, seconds_p2}), 32'(14'b000_0001_000_0000));

    set_ld(23 * 3600 + 59 * 60 + 58); load = 1'b1;
    step();
    check_val("load_no_tick", 32'(tick_1hz), 32'd0);
    wrap_cnt = 0;
    repeat (8) step();
    check_val("wrap_once", wrap_cnt, 1);

    set_ld(0); ld_hours_p1 = 2'd2; ld_hours_p2 = 4'd4; load = 1'b1; step();
    set_ld(0); ld_minutes_p1 = 3'd6; load = 1'b1; step();
    set_ld(0); ld_seconds_p2 = 4'd10; load = 1'b1; step();
    set_ld(0); ld_hours_p1 = 2'd3; alarm_load = 1'b1; step();

    set_ld(7 * 3600 + 30 * 60); alarm_load = 1'b1; step();
    alarm_en = 1'b1;
    set_ld(7 * 3600 + 29 * 60 + 58); load = 1'b1; step();
    hit_cnt = 0;
    repeat (12) step();
    check_val("alarm_once", hit_cnt, 1);
    alarm_en = 1'b0;
    set_ld(7 * 3600 + 29 * 60 + 58); load = 1'b1; step();
    hit_cnt = 0;
    repeat (12) step();
    check_val("alarm_off", hit_cnt, 0);
    alarm_en = 1'b1;
    set_ld(7 * 3600 + 30 * 60); load = 1'b1; step();
    check_val("alarm_load_land", 32'(alarm_hit), 32'd0);

    run = 1'b0; mode_12h = 1'b1;
    set_ld(15 * 60); load = 1'b1; step();
    check_val("h12_midnight", 32'({hours_p1, hours_p2, pm}), 32'({2'd1, 4'd2, 1'b0}));
    set_ld(12 * 3600); load = 1'b1; step();
    set_ld(13 * 3600 + 5 * 60); load = 1'b1; step();
    check_val("h12_pm", 32'({hours_p1, hours_p2, pm}), 32'({2'd0, 4'd1, 1'b1}));
    mode_12h = 1'b0; step();
    check_val("h24_back", 32'({hours_p1, hours_p2}), 32'h13);

    repeat (20) step();
    run = 1'b1;
    step(); step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_val("async_reset", 32'({hours_p1, hours_p2, minutes_p1, minutes_p2, seconds_p1, seconds_p2}), 32'd0);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      run      = ($urandom_range(0, 9) != 0);
      mode_12h = 1'($urandom_range(0, 1));
      alarm_en = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        ld_hours_p1   = 2'($urandom_range(0, 3));
        ld_hours_p2   = 4'($urandom_range(0, 10));
        ld_minutes_p1 = 3'($urandom_range(0, 6));
        ld_minutes_p2 = 4'($urandom_range(0, 10));
        ld_seconds_p1 = 3'($urandom_range(0, 6));
        ld_seconds_p2 = 4'($urandom_range(0, 10));
        load = 1'b1;
        alarm_load = ($urandom_range(0, 1) == 0);
      end else if (r < 6) begin
        set_ld((m_alarm * 60 + 86400 - int'($urandom_range(1, 3))) % 86400);
        load = 1'b1;
      end else if (r < 8) begin
        set_ld(86400 - int'($urandom_range(1, 3)));
        load = 1'b1;
      end else if (r < 11) begin
        set_ld(int'($urandom_range(0, 86399)));
        ld_minutes_p1 = 3'($urandom_range(0, 6));
        alarm_load = 1'b1;
      end
      if (r == 99) reset = 1'b0;
      step();
      reset = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
